// File: rtl/hilo_ctrl.sv
// hilo_ctrl: EX-stage HI/LO registers plus the launch/capture/clear sequencer
// for the shift-add multiplier, with MTHI/MTLO writes and MFHI/MFLO reads.
module hilo_ctrl #(
   parameter int MAX_CYCLES = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MultE,
   input  logic        MfhiE,
   input  logic        MfloE,
   input  logic        MthiE,
   input  logic        MtloE,
   input  logic        FlushE,
   input  logic [31:0] SrcAE,
   input  logic        mult_completed,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   output logic        mult_go,
   output logic        mult_clr,
   output logic        StallMultE,
   output logic [31:0] HiLoOutE,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        mult_err
);
   typedef enum logic [1:0] {IDLE, RUN, CLEAR, DONE} state_t;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic idle, run, start, mthi_w, mtlo_w, timeout;
   always_comb begin
      idle       = state == IDLE;
      run        = state == RUN;
      start      = idle & MultE & ~FlushE;
      // MultE outranks MTHI, which outranks MTLO, when several are raised together
      mthi_w     = idle & MthiE & ~FlushE & ~MultE;
      mtlo_w     = idle & MtloE & ~FlushE & ~MultE & ~MthiE;
      timeout    = cnt == CW'(MAX_CYCLES - 1);
      state_nx   = idle ? (start ? RUN : IDLE) :
                   run ? ((mult_completed | timeout) ? CLEAR : RUN) :
                   state == CLEAR ? DONE : IDLE;
      mult_go    = start | run;
      mult_clr   = state == CLEAR;
      StallMultE = start | run | (state == CLEAR);
      busy       = ~idle;
      HiLoOutE   = MfhiE ? hi : (MfloE ? lo : 32'd0);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         mult_err <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= run ? cnt + 1'b1 : '0;
         if (run && mult_completed) begin
            hi <= mult_hi;
            lo <= mult_lo;
         end
         if (mthi_w) hi <= SrcAE;
         if (mtlo_w) lo <= SrcAE;
         if (run && !mult_completed && timeout) mult_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed vectors for hilo_ctrl with a behavioural multiplier
// stand-in whose latency and operands are set per test.
module tb_hilo_ctrl;
   logic        clk = 0, rst = 1;
   logic        MultE = 0, MfhiE = 0, MfloE = 0, MthiE = 0, MtloE = 0, FlushE = 0;
   logic [31:0] SrcAE = 0;
   logic        mult_completed;
   logic [31:0] mult_hi, mult_lo;
   logic        mult_go, mult_clr, StallMultE, busy, mult_err;
   logic [31:0] HiLoOutE, hi, lo;
   int tests = 0, fails = 0;

   hilo_ctrl dut (
      .clk(clk), .rst(rst), .MultE(MultE), .MfhiE(MfhiE), .MfloE(MfloE),
      .MthiE(MthiE), .MtloE(MtloE), .FlushE(FlushE), .SrcAE(SrcAE),
      .mult_completed(mult_completed), .mult_hi(mult_hi), .mult_lo(mult_lo),
      .mult_go(mult_go), .mult_clr(mult_clr), .StallMultE(StallMultE),
      .HiLoOutE(HiLoOutE), .hi(hi), .lo(lo), .busy(busy), .mult_err(mult_err)
   );

   always #5 clk = ~clk;

   // multiplier stand-in: completes after lat cycles of mult_go, cleared by rst or mult_clr
   logic [31:0] op_a = 0, op_b = 0;
   int          lat = 1000, mcnt = 0;
   logic        mdone = 0;
   logic [63:0] prod;
   assign prod = {32'd0, op_a} * {32'd0, op_b};
   assign mult_completed = mdone;
   assign mult_hi = mdone ? prod[63:32] : 32'd0;
   assign mult_lo = mdone ? prod[31:0] : 32'd0;
   always @(posedge clk) begin
      if (rst || mult_clr) begin
         mcnt  <= 0;
         mdone <= 0;
      end else if (mult_go && !mdone) begin
         mcnt <= mcnt + 1;
         if (mcnt == lat - 1) mdone <= 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // called just after a negedge in IDLE; returns just after the negedge following DONE
   task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input int l,
                          input logic [31:0] eh, input logic [31:0] el, input logic eerr,
                          input int eruns, input logic next_mult);
      int runs = 0, stalls = 0;
      bit seen = 0;
      op_a = a; op_b = b; lat = l; MultE = 1;
      for (int i = 0; i < 200 && !seen; i++) begin
         #1;
         if (StallMultE) stalls++;
         if (busy && mult_go) runs++;
         if (mult_clr) begin
            seen = 1;
            chk("clear_hi", hi, eh);
            chk("clear_lo", lo, el);
            chk("clear_err", {31'd0, mult_err}, {31'd0, eerr});
            chk("clear_go", {31'd0, mult_go}, 32'd0);
            chk("clear_stall", {31'd0, StallMultE}, 32'd1);
         end
         @(negedge clk);
      end
      chk("clear_seen", {31'd0, seen}, 32'd1);
      chk("run_cycles", runs, eruns);
      chk("stall_cycles", stalls, eruns + 2);
      #1;
      chk("done_stall", {31'd0, StallMultE}, 32'd0);
      chk("done_busy", {31'd0, busy}, 32'd1);
      chk("done_go_ignores_multe", {31'd0, mult_go}, 32'd0);
      chk("done_clr", {31'd0, mult_clr}, 32'd0);
      MultE = next_mult;
      @(negedge clk);
   endtask

   typedef struct {
      logic mult, mfhi, mflo, mthi, mtlo, flush;
      logic [31:0] src;
      logic stall, go, busy;
      logic [31:0] hl;
   } vec_t;
   vec_t v[12];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //        mult mfhi mflo mthi mtlo flush src           stall go busy hl
      v[0]  = '{0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0};
      v[1]  = '{0, 0, 0, 1, 0, 0, 32'hDEADBEEF, 0, 0, 0, 32'h0};
      v[2]  = '{0, 1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'hDEADBEEF};
      v[3]  = '{0, 0, 0, 0, 1, 0, 32'h1234,     0, 0, 0, 32'h0};
      v[4]  = '{0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h1234};
      v[5]  = '{1, 0, 0, 0, 0, 1, 32'h0,        0, 0, 0, 32'h0};
      v[6]  = '{0, 0, 0, 1, 0, 1, 32'h5555,     0, 0, 0, 32'h0};
      v[7]  = '{0, 1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'hDEADBEEF};
      v[8]  = '{0, 0, 0, 1, 1, 0, 32'hAAAA,     0, 0, 0, 32'h0};
      v[9]  = '{0, 1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'hAAAA};
      v[10] = '{0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h1234};
      v[11] = '{0, 1, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'hAAAA};

      repeat (3) @(negedge clk);
      rst = 0;
      #1;
      chk("reset_hi", hi, 32'h0);
      chk("reset_lo", lo, 32'h0);
      chk("reset_err", {31'd0, mult_err}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_outs", {29'd0, mult_go, mult_clr, StallMultE}, 32'd0);
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         {MultE, MfhiE, MfloE, MthiE, MtloE, FlushE} =
            {v[i].mult, v[i].mfhi, v[i].mflo, v[i].mthi, v[i].mtlo, v[i].flush};
         SrcAE = v[i].src;
         #1;
         chk($sformatf("vec%0d_stall", i), {31'd0, StallMultE}, {31'd0, v[i].stall});
         chk($sformatf("vec%0d_go", i), {31'd0, mult_go}, {31'd0, v[i].go});
         chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, v[i].busy});
         chk($sformatf("vec%0d_hilo", i), HiLoOutE, v[i].hl);
         @(negedge clk);
      end
      {MultE, MfhiE, MfloE, MthiE, MtloE, FlushE} = '0;
      #1;
      chk("flush_no_state", {31'd0, busy}, 32'd0);
      @(negedge clk);

      do_mult(32'd7, 32'd6, 34, 32'h0, 32'd42, 1'b0, 34, 1'b0);
      #1;
      chk("after_mult_busy", {31'd0, busy}, 32'd0);
      chk("after_mult_stall", {31'd0, StallMultE}, 32'd0);
      @(negedge clk);

      do_mult(32'hFFFFFFFF, 32'd2, 34, 32'h1, 32'hFFFFFFFE, 1'b0, 34, 1'b1);
      do_mult(32'd3, 32'd5, 34, 32'h0, 32'd15, 1'b0, 34, 1'b0);
      #1;
      chk("no_third_run_busy", {31'd0, busy}, 32'd0);
      chk("no_third_run_go", {31'd0, mult_go}, 32'd0);
      @(negedge clk);

      do_mult(32'd9, 32'd9, 1000, 32'h0, 32'd15, 1'b1, 40, 1'b0);
      #1;
      chk("timeout_idle", {31'd0, busy}, 32'd0);
      chk("timeout_sticky", {31'd0, mult_err}, 32'd1);
      @(negedge clk);

      op_a = 32'd2; op_b = 32'd2; lat = 1000; MultE = 1;
      repeat (11) @(negedge clk);
      #1;
      chk("midrun_busy", {31'd0, busy}, 32'd1);
      rst = 1;
      MultE = 0;
      @(negedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_go", {31'd0, mult_go}, 32'd0);
      chk("rst_err", {31'd0, mult_err}, 32'd0);
      rst = 0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- Sits in the EX stage, directly downstream of the shift-add multiplier.
- Launches the multiplier for a MULT in EX and stalls the pipeline while it runs.
- Captures the multiplier's hi/lo into the architectural HI/LO registers, then clears the multiplier so it can run again.
- Also services MTHI/MTLO writes and MFHI/MFLO reads in EX.

Parameters:
MAX_CYCLES, 40, RUN-state cycle limit; if the multiplier has not completed by then, abort and flag an error.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
MultE  input  1  MULT instruction in EX
MfhiE  input  1  MFHI in EX
MfloE  input  1  MFLO in EX
MthiE  input  1  MTHI in EX
MtloE  input  1  MTLO in EX
FlushE  input  1  EX instruction squashed; suppresses all EX-stage actions this cycle
SrcAE  input  32  rs operand; data for MTHI/MTLO
mult_completed  input  1  multiplier completed flag
mult_hi  input  32  multiplier hi result
mult_lo  input  32  multiplier lo result
mult_go  output  1  drives the multiplier's MultE input
mult_clr  output  1  one-cycle clear pulse; the top level ORs it into the multiplier reset
StallMultE  output  1  stall for F/D/E; flush M
HiLoOutE  output  32  MFHI/MFLO result
hi  output  32  architectural HI register
lo  output  32  architectural LO register
busy  output  1  state != IDLE
mult_err  output  1  sticky timeout flag

Behaviour:
- Reset:
  - Synchronous on the rst edge only; no asynchronous behaviour.
  - Takes priority over everything, including mid-multiply.
  - state=IDLE, hi=lo=0, cycle counter=0, mult_err=0.
  - All combinational outputs deassert when state=IDLE and no EX request.
- States: IDLE, RUN, CLEAR, DONE (2-bit encoding).
- IDLE:
  - Start condition: start = MultE & ~FlushE.
  - On start: mult_go=1, StallMultE=1; next state RUN, counter cleared.
  - MthiE & ~FlushE: hi<=SrcAE at the edge.
  - MtloE & ~FlushE: lo<=SrcAE at the edge.
  - If more than one of MultE/MthiE/MtloE is asserted (illegal), priority is MultE > MthiE > MtloE; only the winner acts.
- RUN:
  - mult_go=1, StallMultE=1, counter increments each cycle.
  - If mult_completed=1: hi<=mult_hi, lo<=mult_lo; go to CLEAR.
  - Else if counter == MAX_CYCLES-1: mult_err<=1, hi/lo unchanged; go to CLEAR.
  - Completion wins over timeout in the same cycle.
- CLEAR:
  - mult_go=0, mult_clr=1, StallMultE=1; go to DONE.
- DONE:
  - StallMultE=0, so the MULT leaves EX at this edge.
  - MultE, Mthi/Mtlo and FlushE are ignored this cycle; the MULT is still in EX.
  - Go to IDLE.
- HiLoOutE:
  - Combinational: MfhiE ? hi : (MfloE ? lo : 0).
  - Reads the register value. A write at edge N is visible to an MF* in EX in cycle N+1; no bypass needed because writes occur in EX.
- StallMultE = (state==IDLE & start) | state==RUN | state==CLEAR.
- busy = state != IDLE.
- mult_err: cleared only by rst.
- FlushE is assumed never asserted while stalled. If asserted in RUN or CLEAR it is ignored; the operation still completes.

Test Plan:
- MULT with SrcAE=7, SrcBE=6, multiplier completes after 34 cycles: StallMultE high from the MultE cycle through CLEAR; hi=0, lo=42 one edge after completed is seen; mult_clr pulses once; busy low after DONE.
- Back-to-back MULT (0xFFFFFFFF×2, then 3×5): second run starts from a cleared multiplier; first gives hi=0x1, lo=0xFFFFFFFE; second gives hi=0, lo=15; DONE ignores the still-asserted MultE, so no spurious third run.
- MTHI with SrcAE=0xDEAD_BEEF, then MFHI the next cycle: HiLoOutE=0xDEADBEEF. MTLO with 0x1234, then MFLO: HiLoOutE=0x1234.
- Timeout: mult_completed held 0: after 40 RUN cycles mult_err=1, hi/lo unchanged, the FSM passes through CLEAR and DONE back to IDLE.
- MultE with FlushE=1: no state change, mult_go=0, StallMultE=0.
- rst asserted mid-RUN (cycle 10): next edge state=IDLE, hi=lo=0, mult_go=0, mult_err=0.
